// File: rtl/srisc_pkg.sv
// Shared definitions for the srisc datapath.
// Opcodes, bus source encoding and the branch condition helper.
package srisc_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [3:0] {
        BUS_NONE,
        BUS_HI,
        BUS_LO,
        BUS_ZHI,
        BUS_ZLO,
        BUS_PC,
        BUS_MDR,
        BUS_IN,
        BUS_C,
        BUS_GPR,
        BUS_BA
    } bus_sel_e;

    function automatic logic cond_met(
        input logic [1:0] c2,
        input logic       is_zero,
        input logic       sign
    );
        unique case (c2)
            2'b00:   cond_met = is_zero;
            2'b01:   cond_met = !is_zero;
            2'b10:   cond_met = !sign;
            default: cond_met = sign;
        endcase
    endfunction

endpackage

// File: rtl/srisc_alu.sv
// srisc ALU: A is Y, B is the bus; 64-bit result feeds Z.
// Only mul/div produce a nonzero high word.
module srisc_alu
    import srisc_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [4:0]      opcode,
    input  logic            inc_pc,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] result
);

    localparam int SW = $clog2(DW);

    logic [SW-1:0]   sh;
    logic [2*DW-1:0] rot_r;
    logic [2*DW-1:0] rot_l;
    logic [2*DW-1:0] ax;
    logic [2*DW-1:0] bx;
    logic [2*DW-1:0] prod;
    logic [DW-1:0]   lo;

    assign sh    = b[SW-1:0];
    assign rot_r = {a, a} >> sh;
    assign rot_l = {a, a} << sh;
    assign ax    = {{DW{a[DW-1]}}, a};
    assign bx    = {{DW{b[DW-1]}}, b};
    assign prod  = ax * bx;

    always_comb begin
        lo     = a + b;
        result = '0;
        case (opcode)
            OP_SUB:          lo = a - b;
            OP_AND, OP_ANDI: lo = a & b;
            OP_OR, OP_ORI:   lo = a | b;
            OP_ROR:          lo = rot_r[DW-1:0];
            OP_ROL:          lo = rot_l[2*DW-1:DW];
            OP_SHR:          lo = a >> sh;
            OP_SHRA:         lo = $unsigned($signed(a) >>> sh);
            OP_SHL:          lo = a << sh;
            OP_NEG:          lo = -b;
            OP_NOT:          lo = ~b;
            default:         lo = a + b;
        endcase
        result = {{DW{1'b0}}, lo};
        if (opcode == OP_MUL) begin
            result = prod;
        end else if (opcode == OP_DIV) begin
            if (b == '0) begin
                result = '0;
            end else begin
                result[DW-1:0]    = $unsigned($signed(a) / $signed(b));
                result[2*DW-1:DW] = $unsigned($signed(a) % $signed(b));
            end
        end
        if (inc_pc) begin
            result = {{DW{1'b0}}, b + 1'b1};
        end
    end

endmodule

// File: rtl/srisc_system.sv
// srisc single-bus datapath with 512x32 RAM and preload port.
// All T-state control comes in on ports; one shared bus per cycle.
module srisc_system
    import srisc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] inport_data,
    input  logic                  inport_data_ready,
    input  logic                  outport_in,
    output logic [DATA_WIDTH-1:0] outport_data,
    input  logic                  HIout,
    input  logic                  LOout,
    input  logic                  Zhi_out,
    input  logic                  Zlo_out,
    input  logic                  PCout,
    input  logic                  MDRout,
    input  logic                  Inport_out,
    input  logic                  Cout,
    input  logic                  MARin,
    input  logic                  Zin,
    input  logic                  PCin,
    input  logic                  MDRin,
    input  logic                  IRin,
    input  logic                  Yin,
    input  logic                  HIin,
    input  logic                  LOin,
    input  logic                  CONin,
    input  logic [4:0]            opcode,
    input  logic                  IncPC,
    input  logic                  Gra,
    input  logic                  Grb,
    input  logic                  Grc,
    input  logic                  Rin,
    input  logic                  Rout,
    input  logic                  BAout,
    output logic                  con_ff_bit,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic                  Mem_enable512x32,
    output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
    output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
    output logic [ADDR_WIDTH-1:0] MAR_address_out,
    input  logic                  mem_overide,
    input  logic [ADDR_WIDTH-1:0] overide_address,
    input  logic [DATA_WIDTH-1:0] overide_data_in
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    logic [DW-1:0]   pc, y, hi, lo, mdr, inreg, outreg;
    logic [26:0]     ir;
    logic [AW-1:0]   mar;
    logic [2*DW-1:0] z, alu_res;
    logic [DW-1:0]   gpr [16];
    logic [DW-1:0]   ram [2**AW];
    logic [DW-1:0]   bus, c_sext, ram_rd;
    logic [3:0]      sel;
    logic            con;
    bus_sel_e        bsel;

    assign sel = ({4{Gra}} & ir[26:23])
               | ({4{Grb}} & ir[22:19])
               | ({4{Grc}} & ir[18:15]);

    assign c_sext = {{(DW-19){ir[18]}}, ir[18:0]};
    assign ram_rd = ram[mar];

    always_comb begin
        bsel = BUS_NONE;
        if (HIout)           bsel = BUS_HI;
        else if (LOout)      bsel = BUS_LO;
        else if (Zhi_out)    bsel = BUS_ZHI;
        else if (Zlo_out)    bsel = BUS_ZLO;
        else if (PCout)      bsel = BUS_PC;
        else if (MDRout)     bsel = BUS_MDR;
        else if (Inport_out) bsel = BUS_IN;
        else if (Cout)       bsel = BUS_C;
        else if (Rout)       bsel = BUS_GPR;
        else if (BAout)      bsel = BUS_BA;
    end

    always_comb begin
        bus = '0;
        unique case (bsel)
            BUS_HI:  bus = hi;
            BUS_LO:  bus = lo;
            BUS_ZHI: bus = z[2*DW-1:DW];
            BUS_ZLO: bus = z[DW-1:0];
            BUS_PC:  bus = pc;
            BUS_MDR: bus = mdr;
            BUS_IN:  bus = inreg;
            BUS_C:   bus = c_sext;
            BUS_GPR: bus = gpr[sel];
            BUS_BA:  bus = (sel == 4'd0) ? '0 : gpr[sel];
            default: bus = '0;
        endcase
    end

    srisc_alu #(.DW(DW)) u_alu (
        .opcode (opcode),
        .inc_pc (IncPC),
        .a      (y),
        .b      (bus),
        .result (alu_res)
    );

    always_ff @(posedge Clock) begin
        if (clear) begin
            pc     <= '0;
            ir     <= '0;
            y      <= '0;
            hi     <= '0;
            lo     <= '0;
            z      <= '0;
            mar    <= '0;
            mdr    <= '0;
            inreg  <= '0;
            outreg <= '0;
            con    <= 1'b0;
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
        end else begin
            if (PCin)   pc     <= bus;
            if (IRin)   ir     <= bus[26:0];
            if (Yin)    y      <= bus;
            if (HIin)   hi     <= bus;
            if (LOin)   lo     <= bus;
            if (Zin)    z      <= alu_res;
            if (MARin)  mar    <= bus[AW-1:0];
            if (MDRin)  mdr    <= Mem_Read ? ram_rd : bus;
            if (Rin)    gpr[sel] <= bus;
            if (outport_in) outreg <= bus;
            if (inport_data_ready) inreg <= inport_data;
            if (CONin) con <= cond_met(ir[20:19], bus == '0, bus[DW-1]);
        end
    end

    // Preload override wins over a normal MDR store; RAM is never cleared.
    always_ff @(posedge Clock) begin
        if (Mem_enable512x32) begin
            if (mem_overide)    ram[overide_address] <= overide_data_in;
            else if (Mem_Write) ram[mar] <= mdr;
        end
    end

    assign outport_data         = outreg;
    assign con_ff_bit           = con;
    assign Mem_to_datapath_out  = ram_rd;
    assign Mem_data_to_chip_out = mdr;
    assign MAR_address_out      = mar;

endmodule

// File: tb/tb_srisc_system.sv
// Directed bench for srisc_system with a queued scoreboard.
// Stimulus pushes expectations; a negedge monitor checks them.
module tb_srisc_system;
    import srisc_pkg::*;

    localparam int K_OUT = 0;
    localparam int K_CON = 1;
    localparam int K_MAR = 2;
    localparam int K_MDR = 3;
    localparam int K_RAM = 4;

    logic        Clock, clear;
    logic [31:0] inport_data;
    logic        inport_data_ready, outport_in;
    logic [31:0] outport_data;
    logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout;
    logic        Inport_out, Cout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
    logic [4:0]  opcode;
    logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
    logic        con_ff_bit;
    logic        Mem_Read, Mem_Write, Mem_enable512x32;
    logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
    logic [8:0]  MAR_address_out;
    logic        mem_overide;
    logic [8:0]  overide_address;
    logic [31:0] overide_data_in;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    srisc_system dut (
        .Clock(Clock), .clear(clear),
        .inport_data(inport_data),
        .inport_data_ready(inport_data_ready),
        .outport_in(outport_in), .outport_data(outport_data),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out),
        .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout),
        .Inport_out(Inport_out), .Cout(Cout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
        .CONin(CONin), .opcode(opcode), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .con_ff_bit(con_ff_bit),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_enable512x32(Mem_enable512x32),
        .Mem_to_datapath_out(Mem_to_datapath_out),
        .Mem_data_to_chip_out(Mem_data_to_chip_out),
        .MAR_address_out(MAR_address_out),
        .mem_overide(mem_overide),
        .overide_address(overide_address),
        .overide_data_in(overide_data_in)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic idle();
        clear = 0; inport_data_ready = 0; outport_in = 0;
        HIout = 0; LOout = 0; Zhi_out = 0; Zlo_out = 0;
        PCout = 0; MDRout = 0; Inport_out = 0; Cout = 0;
        MARin = 0; Zin = 0; PCin = 0; MDRin = 0; IRin = 0;
        Yin = 0; HIin = 0; LOin = 0; CONin = 0;
        opcode = 5'b0; IncPC = 0;
        Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        Mem_Read = 0; Mem_Write = 0; Mem_enable512x32 = 0;
        mem_overide = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic expect_v(string name, int kind, logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic probe(string name, logic [31:0] v);
        outport_in = 1;
        tick();
        expect_v(name, K_OUT, v);
    endtask

    task automatic fetch();
        PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
        Zlo_out = 1; PCin = 1; Mem_Read = 1; MDRin = 1; tick();
        MDRout = 1; IRin = 1; tick();
    endtask

    task automatic set_in(logic [31:0] v);
        inport_data = v;
        inport_data_ready = 1;
        tick();
    endtask

    task automatic alu_op(logic [4:0] op);
        Inport_out = 1; opcode = op; Zin = 1; tick();
    endtask

    always @(negedge Clock) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.kind)
                K_OUT:   act = outport_data;
                K_CON:   act = {31'b0, con_ff_bit};
                K_MAR:   act = {23'b0, MAR_address_out};
                K_MDR:   act = Mem_data_to_chip_out;
                default: act = Mem_to_datapath_out;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s actual=%h required=%h",
                         e.name, act, e.exp);
            end
        end
    end

    initial begin
        logic [8:0]  pa [4];
        logic [31:0] pd [4];
        int          n;
        pa[0] = 9'd0; pd[0] = 32'hB300_0000;
        pa[1] = 9'd1; pd[1] = 32'hB380_0000;
        pa[2] = 9'd2; pd[2] = 32'hA300_0000;
        pa[3] = 9'd5; pd[3] = 32'hABF8_0000;
        inport_data = 0;
        overide_address = 0;
        overide_data_in = 0;
        idle();
        clear = 1;
        tick();
        expect_v("rst_outport", K_OUT, 32'h0);
        expect_v("rst_con", K_CON, 32'h0);
        expect_v("rst_mar", K_MAR, 32'h0);
        expect_v("rst_mdr", K_MDR, 32'h0);
        PCout = 1; probe("rst_pc", 32'h0);

        for (int i = 0; i < 4; i++) begin
            Mem_enable512x32 = 1; mem_overide = 1;
            overide_address = pa[i]; overide_data_in = pd[i];
            tick();
        end
        expect_v("ram0_read", K_RAM, 32'hB300_0000);

        fetch();
        expect_v("fetch0_mdr", K_MDR, 32'hB300_0000);
        set_in(32'd5);
        Gra = 1; Rin = 1; Inport_out = 1; tick();
        Gra = 1; Rout = 1; probe("in_r6", 32'd5);
        PCout = 1; probe("pc_after_in1", 32'd1);

        fetch();
        set_in(32'd9);
        Gra = 1; Rin = 1; Inport_out = 1; tick();
        Gra = 1; Rout = 1; probe("in_r7", 32'd9);
        PCout = 1; probe("pc_after_in2", 32'd2);

        fetch();
        Gra = 1; Rout = 1; PCin = 1; tick();
        PCout = 1; probe("jr_pc", 32'd5);

        fetch();
        PCout = 1; Grb = 1; Rin = 1; tick();
        Grb = 1; Rout = 1; probe("jal_r15", 32'd6);
        Gra = 1; Rout = 1; PCin = 1; tick();
        PCout = 1; probe("jal_pc", 32'd9);

        set_in(32'd7);
        Inport_out = 1; Yin = 1; tick();
        set_in(32'd3);
        alu_op(OP_ADD);
        Zlo_out = 1; probe("add_lo", 32'd10);
        Zhi_out = 1; probe("add_hi", 32'd0);
        alu_op(OP_SUB);
        Zlo_out = 1; probe("sub_lo", 32'd4);
        alu_op(OP_AND);
        Zlo_out = 1; probe("and_lo", 32'd3);
        alu_op(OP_MUL);
        Zlo_out = 1; probe("mul_lo", 32'd21);
        Zhi_out = 1; probe("mul_hi", 32'd0);
        alu_op(OP_DIV);
        Zlo_out = 1; probe("div_lo", 32'd2);
        Zhi_out = 1; probe("div_hi", 32'd1);
        set_in(32'd0);
        alu_op(OP_DIV);
        Zlo_out = 1; probe("div0_lo", 32'd0);
        Zhi_out = 1; probe("div0_hi", 32'd0);

        set_in(32'd1);
        Inport_out = 1; Yin = 1; tick();
        alu_op(OP_ROR);
        Zlo_out = 1; probe("ror_lo", 32'h8000_0000);

        Zlo_out = 1; CONin = 1; tick();
        expect_v("con_neg", K_CON, 32'd1);
        Inport_out = 1; CONin = 1; tick();
        expect_v("con_pos", K_CON, 32'd0);

        Zlo_out = 1; PCout = 1; probe("bus_prio", 32'h8000_0000);

        Zlo_out = 1; Grc = 1; Rin = 1; tick();
        Grc = 1; Rout = 1; probe("r0_rout", 32'h8000_0000);
        Grc = 1; BAout = 1; probe("r0_baout", 32'h0);
        Gra = 1; BAout = 1; probe("r7_baout", 32'd9);

        clear = 1;
        tick();
        PCout = 1; probe("clr_pc", 32'h0);
        Cout = 1; probe("clr_ir", 32'h0);
        expect_v("clr_mar", K_MAR, 32'h0);
        fetch();
        expect_v("clr_ram0", K_MDR, 32'hB300_0000);
        Gra = 1; Rout = 1; probe("clr_r6", 32'h0);
        PCout = 1; probe("clr_pc_fetch", 32'd1);

        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge Clock);
            n++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain pending=%0d required=0", q.size());
            failures += q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
